// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Command-side controller for the ProgramCounter + program ROM
//               pair. It runs a small sequence ISA (NOP, JMP, WAIT, OUT, SETL,
//               DJNZ, HALT) and emits one-hot reset/load/inc PC commands.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              tick,
  input  logic [ADDR_W+3:0] instr,
  output logic              pc_reset,
  output logic              pc_load,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] pc_reset_val,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] out_port,
  output logic              busy,
  output logic              halted
);

  localparam logic [3:0] c_OP_JMP  = 4'h1;
  localparam logic [3:0] c_OP_WAIT = 4'h2;
  localparam logic [3:0] c_OP_OUT  = 4'h3;
  localparam logic [3:0] c_OP_SETL = 4'h4;
  localparam logic [3:0] c_OP_DJNZ = 4'h5;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  localparam logic [ADDR_W-1:0] c_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_DECODE = 3'd3,
    S_WAIT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_pc_reset;
  logic              r_pc_load;
  logic              r_pc_inc;
  logic [ADDR_W-1:0] r_load_val;
  logic [ADDR_W-1:0] r_out_port;
  logic [ADDR_W-1:0] r_loop_cnt;
  logic [ADDR_W-1:0] r_wait_cnt;

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic [ADDR_W-1:0] w_loop_dec;

  assign w_opcode   = instr[ADDR_W+3:ADDR_W];
  assign w_operand  = instr[ADDR_W-1:0];
  assign w_loop_dec = r_loop_cnt - c_ONE;

  // Commands are cleared every cycle so each one lives only in the ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc_reset <= 1'b0;
      r_pc_load  <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_load_val <= '0;
      r_out_port <= '0;
      r_loop_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_pc_reset <= 1'b0;
      r_pc_load  <= 1'b0;
      r_pc_inc   <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_HALT: begin
            if (start) begin
              r_state    <= S_ISSUE;
              r_pc_reset <= 1'b1;
            end
          end
          S_ISSUE:  r_state <= S_SETTLE;
          S_SETTLE: r_state <= S_DECODE;
          S_DECODE: begin
            r_state <= S_ISSUE;
            case (w_opcode)
              c_OP_JMP: begin
                r_pc_load  <= 1'b1;
                r_load_val <= w_operand;
              end
              c_OP_WAIT: begin
                r_wait_cnt <= w_operand;
                if (w_operand == '0) r_pc_inc <= 1'b1;
                else                 r_state  <= S_WAIT;
              end
              c_OP_OUT: begin
                r_out_port <= w_operand;
                r_pc_inc   <= 1'b1;
              end
              c_OP_SETL: begin
                r_loop_cnt <= w_operand;
                r_pc_inc   <= 1'b1;
              end
              c_OP_DJNZ: begin
                // A zero count wraps to all-ones here, so the branch is taken.
                r_loop_cnt <= w_loop_dec;
                if (w_loop_dec != '0) begin
                  r_pc_load  <= 1'b1;
                  r_load_val <= w_operand;
                end else begin
                  r_pc_inc <= 1'b1;
                end
              end
              c_OP_HALT: r_state  <= S_HALT;
              default:   r_pc_inc <= 1'b1;
            endcase
          end
          S_WAIT: begin
            if (tick) begin
              r_wait_cnt <= r_wait_cnt - c_ONE;
              if (r_wait_cnt == c_ONE) begin
                r_state  <= S_ISSUE;
                r_pc_inc <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pc_reset     = r_pc_reset;
  assign pc_load      = r_pc_load;
  assign pc_inc       = r_pc_inc;
  assign pc_reset_val = RESET_ADDR;
  assign pc_load_val  = r_load_val;
  assign out_port     = r_out_port;
  assign busy         = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted       = (r_state == S_HALT);

endmodule
`default_nettype wire
